// File: rtl/cic_comb_decimator_if.sv
// Sample stream bundle between the last integrator and the decimating comb section.
// master: upstream producer and output consumer; slave: the comb decimator.
interface cic_comb_decimator_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 12
);
  logic signed [IW-1:0] i_data;
  logic                 i_ready;
  logic signed [OW-1:0] o_data;
  logic                 o_ready;

  modport master (output i_data, output i_ready, input o_data, input o_ready);
  modport slave  (input i_data, input i_ready, output o_data, output o_ready);
endinterface

// File: rtl/cic_comb_decimator.sv
// Decimating comb section of a CIC filter: keeps every R-th strobed sample and
// runs it through N pipelined comb stages (y = x - x[-M]) at IW-bit modular width.
// Optional build macro CIC_COMB_ROUND_EN: round-half-up (saturating) output
// reduction instead of plain truncation of the IW-OW dropped LSBs.
module cic_comb_decimator #(
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 12,
  parameter int unsigned R  = 4,
  parameter int unsigned M  = 1,
  parameter int unsigned N  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  cic_comb_decimator_if.slave bus
);
  localparam int unsigned CW   = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned DROP = IW - OW;

  logic [CW-1:0] cnt;
  logic          accept;
  logic [N-1:0]  vld;
  logic [N:0]    tok;
  logic [IW-1:0] chain [N+1];

  assign accept   = bus.i_ready && (cnt == CW'(R - 1));
  assign tok      = {vld, accept};
  assign chain[0] = bus.i_data;

  // Decimation counter, advances only on strobed edges
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (bus.i_ready) begin
      cnt <= accept ? '0 : cnt + CW'(1);
    end
  end

  // Valid token pipeline, one bit per comb stage
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld <= '0;
    end else begin
      vld <= tok[N-1:0];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [IW-1:0] stg;
    logic [IW-1:0] dly [M];

    assign chain[k+1] = stg;

    // Comb stage: difference against the M-th previous input, then shift it in
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        stg <= '0;
        for (int j = 0; j < int'(M); j++) dly[j] <= '0;
      end else if (tok[k]) begin
        stg    <= chain[k] - dly[M-1];
        dly[0] <= chain[k];
        for (int j = 1; j < int'(M); j++) dly[j] <= dly[j-1];
      end
    end
  end

  assign bus.o_ready = vld[N-1];

  // Output width reduction from the last stage register
  if (DROP == 0) begin : g_full
    assign bus.o_data = chain[N];
  end else begin : g_reduce
`ifdef CIC_COMB_ROUND_EN
    localparam logic [IW-1:0] HALF = IW'(64'd1 << (DROP - 1));
    localparam logic [OW-1:0] OMAX = OW'((64'd1 << (OW - 1)) - 64'd1);
    logic [IW-1:0]   sum;
    logic            ovf;
    logic [DROP-1:0] unused_lsb;

    assign sum        = chain[N] + HALF;
    // Only a non-negative value can cross into the sign bit when adding HALF
    assign ovf        = !chain[N][IW-1] && sum[IW-1];
    assign unused_lsb = sum[DROP-1:0];
    assign bus.o_data = ovf ? OMAX : sum[IW-1 -: OW];
`else
    logic [DROP-1:0] unused_lsb;

    assign unused_lsb = chain[N][DROP-1:0];
    assign bus.o_data = chain[N][IW-1 -: OW];
`endif
  end
endmodule

// File: tb/tb_cic_comb_decimator.sv
// Scoreboard bench for cic_comb_decimator: four instances cover the directed
// cases (R=1/N=1 wrap, R=4 decimation, 8->4 bit reduction, N=3/M=2/R=2 gapped).
module tb_cic_comb_decimator;
  typedef struct {
    logic [15:0] d;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned edge_cnt = 0;
  int          compared = 0;
  int          mismatched = 0;

  exp_t        sb [4][$];
  int unsigned cnt_b = 0;
  int unsigned cnt_d = 0;
  logic [15:0] hist_d [$];

  logic [15:0] exp_b [12] = '{16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0,
                              16'd0, 16'd4, 16'd0, 16'd0, 16'd0, 16'd4};
  logic [15:0] dv [16] = '{16'd100, 16'd2000, 16'd300, 16'd4000, 16'd5000, 16'hF000,
                           16'd1234, 16'd7, 16'd30000, 16'h8001, 16'd555, 16'hFFFF,
                           16'd40, 16'h7FFF, 16'h1111, 16'd9};

`ifdef CIC_COMB_ROUND_EN
  localparam logic [15:0] C24 = 16'd2;
`else
  localparam logic [15:0] C24 = 16'd1;
`endif

  cic_comb_decimator_if #(.IW(8),  .OW(8))  bus_a ();
  cic_comb_decimator_if #(.IW(8),  .OW(8))  bus_b ();
  cic_comb_decimator_if #(.IW(8),  .OW(4))  bus_c ();
  cic_comb_decimator_if #(.IW(16), .OW(12)) bus_d ();

  cic_comb_decimator #(.IW(8), .OW(8), .R(1), .M(1), .N(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a.slave));
  cic_comb_decimator #(.IW(8), .OW(8), .R(4), .M(1), .N(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b.slave));
  cic_comb_decimator #(.IW(8), .OW(4), .R(1), .M(1), .N(1)) dut_c (
    .i_clk(clk), .i_reset(rst), .bus(bus_c.slave));
  cic_comb_decimator #(.IW(16), .OW(12), .R(2), .M(2), .N(3)) dut_d (
    .i_clk(clk), .i_reset(rst), .bus(bus_d.slave));

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // 16 -> 12 bit output reduction expected from instance d
  function automatic logic [15:0] red16(input logic [15:0] v);
`ifdef CIC_COMB_ROUND_EN
    logic [15:0] s;
    s = v + 16'd8;
    if (!v[15] && s[15]) return 16'h07FF;
    return {4'b0, s[15:4]};
`else
    return {4'b0, v[15:4]};
`endif
  endfunction

  function automatic logic [15:0] tap(input int unsigned k);
    int unsigned n;
    n = hist_d.size();
    if (k >= n) return 16'd0;
    return hist_d[n - 1 - k];
  endfunction

  // Three cascaded M=2 combs: (1 - z^-2)^3 = 1 - 3z^-2 + 3z^-4 - z^-6
  function automatic logic [15:0] model_d();
    logic [15:0] y;
    y = tap(0) - 16'd3 * tap(2) + 16'd3 * tap(4) - tap(6);
    return red16(y);
  endfunction

  task automatic push_exp(input int id, input logic [15:0] e, input int unsigned lat);
    exp_t x;
    x.d  = e;
    x.at = edge_cnt + lat;
    sb[id].push_back(x);
  endtask

  task automatic expect_eq(input string nm, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // One strobe cycle on instance id; e is the expected output if it is accepted
  task automatic step(input int id, input logic [15:0] d, input logic [15:0] e);
    case (id)
      0: begin
        bus_a.i_data = d[7:0]; bus_a.i_ready = 1'b1;
        push_exp(0, e, 1);
      end
      1: begin
        bus_b.i_data = d[7:0]; bus_b.i_ready = 1'b1;
        if (cnt_b == 3) begin push_exp(1, e, 1); cnt_b = 0; end
        else cnt_b++;
      end
      2: begin
        bus_c.i_data = d[7:0]; bus_c.i_ready = 1'b1;
        push_exp(2, e, 1);
      end
      default: begin
        bus_d.i_data = d; bus_d.i_ready = 1'b1;
        if (cnt_d == 1) begin
          hist_d.push_back(d);
          push_exp(3, model_d(), 3);
          cnt_d = 0;
        end else cnt_d = 1;
      end
    endcase
    @(negedge clk);
    bus_a.i_ready = 1'b0;
    bus_b.i_ready = 1'b0;
    bus_c.i_ready = 1'b0;
    bus_d.i_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4; i++) sb[i].delete();
    cnt_b = 0;
    cnt_d = 0;
    hist_d.delete();
  endtask

  task automatic do_reset();
    #1;
    for (int i = 0; i < 4; i++) expect_eq($sformatf("drained_%0d", i), 16'(sb[i].size()), 16'd0);
    rst = 1'b1;
    clear_models();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check(input int id, input logic [15:0] act);
    exp_t e;
    compared++;
    if (sb[id].size() == 0) begin
      mismatched++;
      $display("FAIL out_%0d unexpected o_ready: got data %0h at edge %0d, required no output",
               id, act, edge_cnt);
      return;
    end
    e = sb[id].pop_front();
    if (act !== e.d) begin
      mismatched++;
      $display("FAIL data_%0d: got %0h, required %0h", id, act, e.d);
    end
    compared++;
    if (edge_cnt != e.at) begin
      mismatched++;
      $display("FAIL latency_%0d: o_ready after edge %0d, required after edge %0d", id, edge_cnt, e.at);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.o_ready) check(0, 16'($unsigned(bus_a.o_data)));
      if (bus_b.o_ready) check(1, 16'($unsigned(bus_b.o_data)));
      if (bus_c.o_ready) check(2, 16'($unsigned(bus_c.o_data)));
      if (bus_d.o_ready) check(3, 16'($unsigned(bus_d.o_data)));
    end
  end

  initial begin
    bus_a.i_data = '0; bus_a.i_ready = 1'b0;
    bus_b.i_data = '0; bus_b.i_ready = 1'b0;
    bus_c.i_data = '0; bus_c.i_ready = 1'b0;
    bus_d.i_data = '0; bus_d.i_ready = 1'b0;

    #1 rst = 1'b1;
    #1;
    expect_eq("rst_ready_a", 16'(bus_a.o_ready), 16'd0);
    expect_eq("rst_ready_b", 16'(bus_b.o_ready), 16'd0);
    expect_eq("rst_ready_c", 16'(bus_c.o_ready), 16'd0);
    expect_eq("rst_ready_d", 16'(bus_d.o_ready), 16'd0);
    expect_eq("rst_data_a", 16'($unsigned(bus_a.o_data)), 16'd0);
    expect_eq("rst_data_b", 16'($unsigned(bus_b.o_data)), 16'd0);
    expect_eq("rst_data_c", 16'($unsigned(bus_c.o_data)), 16'd0);
    expect_eq("rst_data_d", 16'($unsigned(bus_d.o_data)), 16'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // R=1 N=1 M=1 first differences
    step(0, 16'd5, 16'd5);
    step(0, 16'd7, 16'd2);
    step(0, 16'd10, 16'd3);
    idle(3);

    // R=4: strobe every cycle, accept every 4th
    for (int i = 0; i < 12; i++) step(1, 16'(i), exp_b[i]);
    idle(3);

    // 8 -> 4 bit reduction, mid value
    step(2, 16'd24, C24);
    idle(3);

    do_reset();

    // Modular wrap through the difference, and saturating/truncating top value
    step(0, 16'd127, 16'd127);
    step(0, 16'h0080, 16'd1);
    step(2, 16'd127, 16'd7);
    idle(3);

    // N=3 M=2 R=2 with 1..3 idle cycles between strobes
    for (int i = 0; i < 16; i++) begin
      step(3, dv[i], 16'd0);
      idle(i % 3 + 1);
    end
    idle(6);

    // Reset with a token in flight
    step(3, 16'h0123, 16'd0);
    step(3, 16'h0456, 16'd0);
    step(3, 16'h0789, 16'd0);
    @(posedge clk);
    #1;
    expect_eq("inflight_ready", 16'(bus_d.o_ready), 16'd1);
    #1 rst = 1'b1;
    #1;
    expect_eq("async_rst_ready", 16'(bus_d.o_ready), 16'd0);
    expect_eq("async_rst_data", 16'($unsigned(bus_d.o_data)), 16'd0);
    clear_models();
    @(negedge clk);
    #1 rst = 1'b0;

    // Partial count and history discarded by reset
    step(3, 16'h0AAA, 16'd0);
    step(3, 16'h0550, 16'd0);
    step(0, 16'd9, 16'd9);
    idle(6);

    for (int i = 0; i < 4; i++) expect_eq($sformatf("leftover_%0d", i), 16'(sb[i].size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cic_comb_decimator.md
# cic_comb_decimator

Decimating comb section of the CIC filter: consumes the full-width sample stream produced by the cascaded `integrator` stages, keeps every R-th strobed sample, and runs it through N pipelined comb (differentiator) stages with differential delay M. It sits directly after the last integrator and drives the filter output. The output is reduced to OW bits.

## Interface
- `IW`, 16: input/internal width; must equal the final integrator's OW.
- `OW`, 12: output width, 1 ≤ OW ≤ IW.
- `R`, 4: decimation ratio, ≥ 1.
- `M`, 1: differential delay in decimated samples, ≥ 1.
- `N`, 3: number of comb stages, ≥ 1.

- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_data`  in  IW  signed sample from the integrator chain.
- `i_ready`  in  1  sample strobe, one cycle per valid `i_data`.
- `o_data`  out  OW  signed decimated, filtered sample.
- `o_ready`  out  1  one-cycle strobe, `o_data` valid.

## Operation
- Decimation counter `cnt` (0..R-1) advances only on edges with `i_ready`=1. A sample is accepted when `i_ready`=1 and `cnt`=R-1, and `cnt` then wraps to 0. With R=1, every strobed sample is accepted.
- Comb stage k (1..N) keeps an M-deep delay line of its own past inputs, counted in accepted samples. On its enable it computes `y = x − x[−M]`, registers `y`, and shifts `x` into the delay line.
- Valid token shift register `vld[1..N]`: `vld[1]` is set on the accepting edge. Stage k+1 updates on an edge where `vld[k]`=1. `o_ready` = `vld[N]`.
- All arithmetic is IW-bit two's complement and wraps modulo 2^IW with no saturation. The wrap is intentional and cancels the integrator wrap.
- `o_data` = top OW bits of the stage-N register, with `IW−OW` LSBs dropped (floor). It holds its value between `o_ready` strobes.
- The integrator stream can strobe every cycle. The pipeline takes one accepted sample per cycle without stalling. No backpressure exists.

## Timing
- Reset (async assert, release sync to `i_clk`) clears `cnt`, every delay line, every stage register and `vld`. Outputs go to `o_data`=0 and `o_ready`=0 immediately on assertion.
- Latency: a sample accepted at edge t produces `o_ready`=1 for exactly the cycle after edge t+N−1. For N=1, this is the cycle right after acceptance.
- `o_ready` is never high for two consecutive cycles when R ≥ 2. When R=1, it can be high continuously.
- Edges with `i_ready`=0 leave `cnt` and the delay lines unchanged. Tokens already in flight still advance.
- Reset mid-operation discards in-flight tokens and partial decimation counts. The first accepted sample after release sees zero history.
- The first M outputs after reset per stage reflect zero-initialised delay lines, which is the normal CIC startup transient.

## Configuration
- `CIC_COMB_ROUND_EN` defined: `o_data` uses round-half-up. The design adds 2^(IW−OW−1) to the stage-N register before dropping LSBs. If the add overflows the positive range, the result saturates to the maximum positive OW value. Latency is unchanged, because rounding is combinational from the stage-N register.
- Not defined: plain truncation (floor).
- If OW=IW, the macro has no effect.

## Test plan
- IW=OW=8, R=1, N=1, M=1: strobes with 5, 7, 10 → `o_data` 5, 2, 3, each `o_ready` exactly 1 cycle after its accepting edge.
- R=4, N=1, M=1: strobe every cycle with data 0..11 → accepted 3, 7, 11 → outputs 3, 4, 4, `o_ready` every 4th cycle.
- IW=OW=8, R=1, N=1, M=1: inputs 127 then −128 → outputs 127, then 1 (modular wrap, no saturation).
- IW=8, OW=4, N=1, R=1: input 24 gives 1 without the macro and 2 with `CIC_COMB_ROUND_EN`. Input 127 gives 7 in both builds, via saturation when the macro is defined.
- N=3, M=2, R=2, with `i_ready` gapped by 1–3 idle cycles: output matches the golden model, and `o_ready` arrives 3 cycles after each accepting edge.
- Assert `i_reset` with tokens in flight → `o_ready` drops within the same cycle. After release, with R=1, N=1, input 9 → output 9.
